// File: rtl/serial_shift_divide_by_pow2.sv
// Bit-serial shifter/divider: one 1-bit shift per clock, result held in DONE
// until the consumer takes it. Modes: logical, arithmetic, signed /2^s, rotate.
module serial_shift_divide_by_pow2 #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] s,
    input  logic [1:0]    mode,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [N-1:0]  res,
    output logic          res_inexact
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  work_q, work_d;
    logic          sticky_q, sticky_d;
    logic [1:0]    mode_q, mode_d;
    logic [N-1:0]  res_q, res_d;
    logic          inexact_q, inexact_d;

    logic [N-1:0]  shift_1;
    logic          lost;
    logic [N-1:0]  round_up;

    always_comb begin
        case (mode_q)
            2'b00:   shift_1 = {1'b0, work_q[N-1:1]};
            2'b11:   shift_1 = {work_q[0], work_q[N-1:1]};
            default: shift_1 = {work_q[N-1], work_q[N-1:1]};
        endcase
        // Rotation loses nothing, so its sticky bit never sets.
        lost = sticky_q | (work_q[0] & (mode_q != 2'b11));
        // Floor -> truncate toward zero: negative values with lost bits move up by one.
        round_up = {{(N-1){1'b0}}, (mode_q == 2'b10) & work_q[N-1] & lost};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        sticky_d  = sticky_q;
        mode_d    = mode_q;
        res_d     = res_q;
        inexact_d = inexact_q;
        case (state_q)
            IDLE: begin
                if (arg_vld) begin
                    mode_d = mode;
                    if (s == '0) begin
                        res_d     = a;
                        inexact_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        work_d   = a;
                        cnt_d    = s;
                        sticky_d = 1'b0;
                        state_d  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d   = shift_1;
                sticky_d = lost;
                cnt_d    = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    res_d     = shift_1 + round_up;
                    inexact_d = lost;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (res_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            sticky_q  <= 1'b0;
            mode_q    <= 2'b00;
            res_q     <= '0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            sticky_q  <= sticky_d;
            mode_q    <= mode_d;
            res_q     <= res_d;
            inexact_q <= inexact_d;
        end
    end

    assign arg_rdy     = (state_q == IDLE);
    assign res_vld     = (state_q == DONE);
    assign res         = res_q;
    assign res_inexact = inexact_q;

endmodule

// File: tb/tb_serial_shift_divide_by_pow2.sv
// Directed + randomized checks of serial_shift_divide_by_pow2 at N = 8.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_shift_divide_by_pow2;

    logic       clk = 1'b0;
    logic       rst, arg_vld, arg_rdy, res_vld, res_rdy, res_inexact;
    logic [7:0] a, res;
    logic [2:0] s;
    logic [1:0] mode;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    serial_shift_divide_by_pow2 #(.N(8)) dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
        .a(a), .s(s), .mode(mode), .res_vld(res_vld), .res_rdy(res_rdy),
        .res(res), .res_inexact(res_inexact)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [7:0] ai, input logic [2:0] si,
                                      input logic [1:0] mi, output logic [7:0] r,
                                      output logic x);
        int q;
        x = (mi != 2'b11) && ((ai & ((8'd1 << si) - 8'd1)) != 8'd0);
        case (mi)
            2'b00: r = ai >> si;
            2'b01: r = $signed(ai) >>> si;
            2'b10: begin
                q = $signed(ai);
                q = q / (1 << si);
                r = q[7:0];
            end
            default: r = (ai >> si) | (ai << (8 - int'(si)));
        endcase
    endfunction

    // Issue one request, check latency and result, hold for 'hold' cycles, then drain.
    task automatic run_req(input logic [7:0] ai, input logic [2:0] si, input logic [1:0] mi,
                           input logic [7:0] er, input logic ex, input int hold);
        int w, lat;
        w = 0;
        while (!arg_rdy && w < 20) begin @(negedge clk); w++; end
        chk("arg_rdy_wait", arg_rdy, 1);
        arg_vld = 1'b1; a = ai; s = si; mode = mi;
        @(negedge clk);
        arg_vld = 1'b0; a = ~ai; s = 3'($urandom); mode = 2'($urandom);
        lat = 0;
        while (!res_vld && lat < 20) begin @(negedge clk); lat++; end
        chk("latency", lat, si);
        chk("res", res, er);
        chk("inexact", res_inexact, ex);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_res", res, er);
            chk("hold_vld", res_vld, 1);
        end
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        chk("back_idle", arg_rdy, 1);
        chk("vld_drop", res_vld, 0);
    endtask

    initial begin
        logic [7:0] r_exp, ra;
        logic       x_exp;
        logic [2:0] rs;
        logic [1:0] rm;
        rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b0; a = '0; s = '0; mode = '0;
        repeat (2) @(negedge clk);
        chk("rst_arg_rdy", arg_rdy, 1);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_res", res, 0);
        chk("rst_inexact", res_inexact, 0);
        rst = 1'b0;
        @(negedge clk);

        // Same operand, every mode.
        run_req(8'h96, 3'd3, 2'b00, 8'h12, 1'b1, 0);
        run_req(8'h96, 3'd3, 2'b01, 8'hF2, 1'b1, 0);
        run_req(8'h96, 3'd3, 2'b10, 8'hF3, 1'b1, 0);
        run_req(8'h96, 3'd3, 2'b11, 8'hD2, 1'b0, 0);
        // Extremes of s and rounding.
        run_req(8'h80, 3'd7, 2'b10, 8'hFF, 1'b0, 0);
        run_req(8'h81, 3'd7, 2'b10, 8'h00, 1'b1, 0);
        run_req(8'h80, 3'd0, 2'b01, 8'h80, 1'b0, 0);
        run_req(8'h01, 3'd7, 2'b11, 8'h02, 1'b0, 0);

        // Backpressure: result parked while arg_vld stays high with changing a.
        arg_vld = 1'b1; a = 8'h96; s = 3'd3; mode = 2'b01;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("bp_vld", res_vld, 1);
        for (int i = 0; i < 5; i++) begin
            a = a ^ 8'hFF;
            @(negedge clk);
            chk("bp_res", res, 8'hF2);
            chk("bp_inexact", res_inexact, 1);
            chk("bp_arg_rdy", arg_rdy, 0);
        end
        arg_vld = 1'b0; res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        chk("bp_idle", arg_rdy, 1);
        @(negedge clk);
        chk("bp_no_accept", arg_rdy, 1);

        // Reset mid-shift abandons the operation.
        arg_vld = 1'b1; a = 8'h96; s = 3'd7; mode = 2'b00;
        @(negedge clk);
        arg_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_shift", arg_rdy, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_arg_rdy", arg_rdy, 1);
        chk("rst2_res", res, 0);
        chk("rst2_inexact", res_inexact, 0);
        for (int i = 0; i < 8; i++) begin
            chk("rst2_no_vld", res_vld, 0);
            @(negedge clk);
        end
        run_req(8'h40, 3'd2, 2'b00, 8'h10, 1'b0, 0);

        // Randomized requests against the reference model.
        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom); rs = 3'($urandom); rm = 2'($urandom);
            ref_model(ra, rs, rm, r_exp, x_exp);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_req(ra, rs, rm, r_exp, x_exp, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
